// File: rtl/fib_ram_sequencer.sv
// fib_ram_sequencer: fills a single-port RAM with saturating Fibonacci terms,
// then plays them back to the display one entry per tick.
module fib_ram_sequencer #(
    parameter int AW  = 4,
    parameter int DW  = 11,
    parameter int LEN = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          tick,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] disp_data,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [1:0]    state_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, INIT = 2'b01, FILL = 2'b10, PLAY = 2'b11} state_t;
    localparam logic [AW-1:0] LAST = AW'(LEN - 1);
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic          a_sat_q, a_sat_d, b_sat_q, b_sat_d;
    logic          done_q, done_d, ovf_q, ovf_d;
    logic [DW:0]   sum;
    logic          sat;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        a_d     = a_q;
        b_d     = b_q;
        a_sat_d = a_sat_q;
        b_sat_d = b_sat_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        sum     = {1'b0, a_q} + {1'b0, b_q};
        sat     = sum[DW] | a_sat_q | b_sat_q;
        case (state_q)
            IDLE: state_d = start ? INIT : IDLE;
            INIT: begin
                a_d     = '0;
                b_d     = DW'(1);
                a_sat_d = 1'b0;
                b_sat_d = 1'b0;
                addr_d  = '0;
                ovf_d   = 1'b0;
                state_d = FILL;
            end
            FILL: begin
                a_d     = b_q;
                a_sat_d = b_sat_q;
                b_d     = sat ? '1 : sum[DW-1:0];
                b_sat_d = sat;
                ovf_d   = ovf_q | a_sat_q;
                addr_d  = (addr_q == LAST) ? '0 : addr_q + AW'(1);
                done_d  = (addr_q == LAST);
                state_d = (addr_q == LAST) ? PLAY : FILL;
            end
            default: begin
                // start wins over stop, stop wins over tick
                if (start) begin
                    state_d = INIT;
                    addr_d  = '0;
                end else if (stop) begin
                    state_d = IDLE;
                end else begin
                    disp_d = ram_dout;
                    addr_d = tick ? ((addr_q == LAST) ? '0 : addr_q + AW'(1)) : addr_q;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_sat_q <= 1'b0;
            b_sat_q <= 1'b0;
            disp_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_sat_q <= a_sat_d;
            b_sat_q <= b_sat_d;
            disp_q  <= disp_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end
    assign ram_we    = (state_q == FILL);
    assign ram_din   = ram_we ? (a_sat_q ? '1 : a_q) : '0;
    assign ram_addr  = addr_q;
    assign disp_data = disp_q;
    assign busy      = (state_q == INIT) || (state_q == FILL);
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_fib_ram_sequencer.sv
// tb_fib_ram_sequencer: three sequencer instances (DW=11/LEN=16, DW=8/LEN=16,
// DW=11/LEN=10) sharing stimulus; write and playback traffic checked via queues.
module tb_fib_ram_sequencer;
    logic clk = 0, rst_n = 0, start = 0, stop = 0, tick = 0;
    always #5 clk = ~clk;

    logic [3:0]  a0, a1, a2;
    logic        we0, we1, we2, busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
    logic [1:0]  st0, st1, st2;
    logic [10:0] din0, dout0, disp0, din2, dout2, disp2;
    logic [7:0]  din1, dout1, disp1;
    logic [10:0] mem0 [16];
    logic [7:0]  mem1 [16];
    logic [10:0] mem2 [16];

    assign dout0 = mem0[a0];
    assign dout1 = mem1[a1];
    assign dout2 = mem2[a2];
    always @(posedge clk) if (we0) mem0[a0] <= din0;
    always @(posedge clk) if (we1) mem1[a1] <= din1;
    always @(posedge clk) if (we2) mem2[a2] <= din2;

    fib_ram_sequencer #(.AW(4), .DW(11), .LEN(16)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .tick(tick), .ram_addr(a0), .ram_we(we0), .ram_din(din0), .ram_dout(dout0), .disp_data(disp0),
        .busy(busy0), .done(done0), .ovf(ovf0), .state_o(st0));
    fib_ram_sequencer #(.AW(4), .DW(8), .LEN(16)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .tick(tick), .ram_addr(a1), .ram_we(we1), .ram_din(din1), .ram_dout(dout1), .disp_data(disp1),
        .busy(busy1), .done(done1), .ovf(ovf1), .state_o(st1));
    fib_ram_sequencer #(.AW(4), .DW(11), .LEN(10)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .tick(tick), .ram_addr(a2), .ram_we(we2), .ram_din(din2), .ram_dout(dout2), .disp_data(disp2),
        .busy(busy2), .done(done2), .ovf(ovf2), .state_o(st2));

    typedef struct {int addr; int data;} exp_t;
    exp_t q0[$], q1[$], q2[$];
    int fib[16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    int checks = 0, failures = 0;
    logic mon2 = 0, pend = 0;
    logic [3:0] prev2 = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function void unexpected(string name, logic [31:0] addr);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at addr %0d, expected none", name, addr);
    endfunction

    always @(negedge clk) begin : mon_w0
        exp_t e;
        if (we0 === 1'b1) begin
            if (q0.size() == 0) unexpected("u0 write", a0);
            else begin
                e = q0.pop_front();
                chk("u0 wr addr", a0, e.addr);
                chk("u0 wr data", din0, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_w1
        exp_t e;
        if (we1 === 1'b1) begin
            if (q1.size() == 0) unexpected("u1 write", a1);
            else begin
                e = q1.pop_front();
                chk("u1 wr addr", a1, e.addr);
                chk("u1 wr data", din1, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_p2
        exp_t e;
        if (mon2 && st2 == 2'b11) begin
            if (pend) begin
                if (q2.size() == 0) unexpected("u2 play", a2);
                else begin
                    e = q2.pop_front();
                    chk("u2 play addr", a2, e.addr);
                    chk("u2 play disp", disp2, e.data);
                end
            end
            pend = (a2 != prev2);
        end
        prev2 = a2;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cyc(); start = 1;
        cyc(); start = 0;
    endtask

    task automatic pulse_tick();
        cyc(); tick = 1;
        cyc(); tick = 0;
        repeat (3) cyc();
    endtask

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back('{i, fib[i]});
            q1.push_back('{i, (fib[i] > 255) ? 255 : fib[i]});
        end
    endtask

    task automatic run_fill(output int nb, output bit ok);
        nb = 0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done0) begin
                ok = 1;
                break;
            end
            if (busy0) nb++;
        end
    endtask

    initial begin
        int nb;
        bit ok, found;
        #2;
        chk("rst state", st0, 0);
        chk("rst addr", a0, 0);
        chk("rst we", we0, 0);
        chk("rst din", din0, 0);
        chk("rst disp", disp0, 0);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst ovf", ovf0, 0);
        cyc(); rst_n = 1;
        cyc();
        // first fill: DW=11 exact, DW=8 saturates at entry 14
        push_fill(16);
        pulse_start();
        run_fill(nb, ok);
        chk("fill1 done seen", ok, 1);
        chk("fill1 busy cycles", nb, 17);
        chk("u1 done same cycle", done1, 1);
        @(negedge clk);
        chk("done one cycle", done0, 0);
        chk("u0 ovf clear", ovf0, 0);
        chk("u1 ovf set", ovf1, 1);
        chk("u0 state play", st0, 3);
        chk("u0 writes consumed", q0.size(), 0);
        chk("u1 writes consumed", q1.size(), 0);
        chk("u2 disp entry0", disp2, 0);
        // playback with wrap at LEN=10
        for (int k = 1; k <= 16; k++) q2.push_back('{k % 10, fib[k % 10]});
        mon2 = 1;
        repeat (12) pulse_tick();
        @(negedge clk);
        chk("u2 play consumed", q2.size(), 4);
        chk("u0 addr after 12 ticks", a0, 12);
        chk("u0 disp after 12 ticks", disp0, 144);
        repeat (4) pulse_tick();
        @(negedge clk);
        chk("u2 play all consumed", q2.size(), 0);
        chk("u2 at addr 6", a2, 6);
        cyc(); stop = 1;
        cyc(); stop = 0;
        mon2 = 0;
        @(negedge clk);
        chk("stop state idle", st2, 0);
        chk("stop disp holds", disp2, 8);
        chk("stop we low", we2, 0);
        repeat (3) pulse_tick();
        @(negedge clk);
        chk("idle tick addr", a2, 6);
        chk("idle tick disp", disp2, 8);
        chk("idle tick state", st2, 0);
        // regenerate; ovf clears in INIT; start during FILL ignored
        push_fill(16);
        pulse_start();
        @(negedge clk);
        chk("u1 init state", st1, 1);
        chk("u1 ovf before init edge", ovf1, 1);
        @(negedge clk);
        chk("u1 ovf cleared", ovf1, 0);
        cyc(); start = 1;
        cyc(); start = 0;
        run_fill(nb, ok);
        chk("fill2 done seen", ok, 1);
        chk("fill2 u0 writes", q0.size(), 0);
        chk("fill2 u1 writes", q1.size(), 0);
        chk("fill2 u1 ovf", ovf1, 1);
        chk("u2 play from 0", a2, 0);
        chk("u2 state play", st2, 3);
        // start+stop+tick together in PLAY
        repeat (2) pulse_tick();
        @(negedge clk);
        chk("u0 addr before simult", a0, 2);
        push_fill(16);
        cyc(); start = 1; stop = 1; tick = 1;
        cyc(); start = 0; stop = 0; tick = 0;
        @(negedge clk);
        chk("simult state init", st0, 1);
        chk("simult addr zero", a0, 0);
        run_fill(nb, ok);
        chk("fill3 done seen", ok, 1);
        chk("fill3 u0 writes", q0.size(), 0);
        chk("fill3 u1 writes", q1.size(), 0);
        // reset mid-fill at address 5
        push_fill(6);
        pulse_start();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = (st0 == 2 && a0 == 5);
        end
        chk("reached addr 5", found, 1);
        #1 rst_n = 0;
        #1;
        chk("mid rst we", we0, 0);
        chk("mid rst busy", busy0, 0);
        chk("mid rst state", st0, 0);
        chk("mid rst u1 we", we1, 0);
        chk("mid rst writes", q0.size(), 0);
        cyc(); rst_n = 1;
        repeat (10) cyc();
        chk("post rst state", st0, 0);
        chk("post rst no writes", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
